aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule. Sits directly upstream of AES_cipher and supplies its round keys.
//  On Start it expands the 128-bit cipher key into NR+1 round keys, one per clock, and stores them in an internal round-key file.
//  The cipher reads the file by round index while running its rounds.

---
 rtl/aes_key_expand_pkg.sv | 22 ++
 rtl/aes_key_expand_sbox.sv | 27 ++
 rtl/aes_key_expand.sv | 90 +++++++++
 tb/tb_aes_key_expand.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_expand_pkg.sv
// aes_key_expand_pkg: shared AES-128 key-schedule constants, FSM states and Rcon lookup.
// Also used by the cipher so both sides agree on NR and key width.
package aes_key_expand_pkg;
    localparam int NR    = 10;
    localparam int KEY_W = 128;
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction
endpackage

// File: rtl/aes_key_expand_sbox.sv
// aes_key_expand_sbox: combinational forward AES S-box, one byte in, one byte out.
module aes_key_expand_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_b
);
    always_comb begin
        o_b = 8'h00;
        case (i_a)
            8'h00: o_b = 8'h63; 8'h01: o_b = 8'h7c; 8'h02: o_b = 8'h77; 8'h03: o_b = 8'h7b; 8'h04: o_b = 8'hf2; 8'h05: o_b = 8'h6b; 8'h06: o_b = 8'h6f; 8'h07: o_b = 8'hc5; 8'h08: o_b = 8'h30; 8'h09: o_b = 8'h01; 8'h0a: o_b = 8'h67; 8'h0b: o_b = 8'h2b; 8'h0c: o_b = 8'hfe; 8'h0d: o_b = 8'hd7; 8'h0e: o_b = 8'hab; 8'h0f: o_b = 8'h76;
            8'h10: o_b = 8'hca; 8'h11: o_b = 8'h82; 8'h12: o_b = 8'hc9; 8'h13: o_b = 8'h7d; 8'h14: o_b = 8'hfa; 8'h15: o_b = 8'h59; 8'h16: o_b = 8'h47; 8'h17: o_b = 8'hf0; 8'h18: o_b = 8'had; 8'h19: o_b = 8'hd4; 8'h1a: o_b = 8'ha2; 8'h1b: o_b = 8'haf; 8'h1c: o_b = 8'h9c; 8'h1d: o_b = 8'ha4; 8'h1e: o_b = 8'h72; 8'h1f: o_b = 8'hc0;
            8'h20: o_b = 8'hb7; 8'h21: o_b = 8'hfd; 8'h22: o_b = 8'h93; 8'h23: o_b = 8'h26; 8'h24: o_b = 8'h36; 8'h25: o_b = 8'h3f; 8'h26: o_b = 8'hf7; 8'h27: o_b = 8'hcc; 8'h28: o_b = 8'h34; 8'h29: o_b = 8'ha5; 8'h2a: o_b = 8'he5; 8'h2b: o_b = 8'hf1; 8'h2c: o_b = 8'h71; 8'h2d: o_b = 8'hd8; 8'h2e: o_b = 8'h31; 8'h2f: o_b = 8'h15;
            8'h30: o_b = 8'h04; 8'h31: o_b = 8'hc7; 8'h32: o_b = 8'h23; 8'h33: o_b = 8'hc3; 8'h34: o_b = 8'h18; 8'h35: o_b = 8'h96; 8'h36: o_b = 8'h05; 8'h37: o_b = 8'h9a; 8'h38: o_b = 8'h07; 8'h39: o_b = 8'h12; 8'h3a: o_b = 8'h80; 8'h3b: o_b = 8'he2; 8'h3c: o_b = 8'heb; 8'h3d: o_b = 8'h27; 8'h3e: o_b = 8'hb2; 8'h3f: o_b = 8'h75;
            8'h40: o_b = 8'h09; 8'h41: o_b = 8'h83; 8'h42: o_b = 8'h2c; 8'h43: o_b = 8'h1a; 8'h44: o_b = 8'h1b; 8'h45: o_b = 8'h6e; 8'h46: o_b = 8'h5a; 8'h47: o_b = 8'ha0; 8'h48: o_b = 8'h52; 8'h49: o_b = 8'h3b; 8'h4a: o_b = 8'hd6; 8'h4b: o_b = 8'hb3; 8'h4c: o_b = 8'h29; 8'h4d: o_b = 8'he3; 8'h4e: o_b = 8'h2f; 8'h4f: o_b = 8'h84;
            8'h50: o_b = 8'h53; 8'h51: o_b = 8'hd1; 8'h52: o_b = 8'h00; 8'h53: o_b = 8'hed; 8'h54: o_b = 8'h20; 8'h55: o_b = 8'hfc; 8'h56: o_b = 8'hb1; 8'h57: o_b = 8'h5b; 8'h58: o_b = 8'h6a; 8'h59: o_b = 8'hcb; 8'h5a: o_b = 8'hbe; 8'h5b: o_b = 8'h39; 8'h5c: o_b = 8'h4a; 8'h5d: o_b = 8'h4c; 8'h5e: o_b = 8'h58; 8'h5f: o_b = 8'hcf;
            8'h60: o_b = 8'hd0; 8'h61: o_b = 8'hef; 8'h62: o_b = 8'haa; 8'h63: o_b = 8'hfb; 8'h64: o_b = 8'h43; 8'h65: o_b = 8'h4d; 8'h66: o_b = 8'h33; 8'h67: o_b = 8'h85; 8'h68: o_b = 8'h45; 8'h69: o_b = 8'hf9; 8'h6a: o_b = 8'h02; 8'h6b: o_b = 8'h7f; 8'h6c: o_b = 8'h50; 8'h6d: o_b = 8'h3c; 8'h6e: o_b = 8'h9f; 8'h6f: o_b = 8'ha8;
            8'h70: o_b = 8'h51; 8'h71: o_b = 8'ha3; 8'h72: o_b = 8'h40; 8'h73: o_b = 8'h8f; 8'h74: o_b = 8'h92; 8'h75: o_b = 8'h9d; 8'h76: o_b = 8'h38; 8'h77: o_b = 8'hf5; 8'h78: o_b = 8'hbc; 8'h79: o_b = 8'hb6; 8'h7a: o_b = 8'hda; 8'h7b: o_b = 8'h21; 8'h7c: o_b = 8'h10; 8'h7d: o_b = 8'hff; 8'h7e: o_b = 8'hf3; 8'h7f: o_b = 8'hd2;
            8'h80: o_b = 8'hcd; 8'h81: o_b = 8'h0c; 8'h82: o_b = 8'h13; 8'h83: o_b = 8'hec; 8'h84: o_b = 8'h5f; 8'h85: o_b = 8'h97; 8'h86: o_b = 8'h44; 8'h87: o_b = 8'h17; 8'h88: o_b = 8'hc4; 8'h89: o_b = 8'ha7; 8'h8a: o_b = 8'h7e; 8'h8b: o_b = 8'h3d; 8'h8c: o_b = 8'h64; 8'h8d: o_b = 8'h5d; 8'h8e: o_b = 8'h19; 8'h8f: o_b = 8'h73;
            8'h90: o_b = 8'h60; 8'h91: o_b = 8'h81; 8'h92: o_b = 8'h4f; 8'h93: o_b = 8'hdc; 8'h94: o_b = 8'h22; 8'h95: o_b = 8'h2a; 8'h96: o_b = 8'h90; 8'h97: o_b = 8'h88; 8'h98: o_b = 8'h46; 8'h99: o_b = 8'hee; 8'h9a: o_b = 8'hb8; 8'h9b: o_b = 8'h14; 8'h9c: o_b = 8'hde; 8'h9d: o_b = 8'h5e; 8'h9e: o_b = 8'h0b; 8'h9f: o_b = 8'hdb;
            8'ha0: o_b = 8'he0; 8'ha1: o_b = 8'h32; 8'ha2: o_b = 8'h3a; 8'ha3: o_b = 8'h0a; 8'ha4: o_b = 8'h49; 8'ha5: o_b = 8'h06; 8'ha6: o_b = 8'h24; 8'ha7: o_b = 8'h5c; 8'ha8: o_b = 8'hc2; 8'ha9: o_b = 8'hd3; 8'haa: o_b = 8'hac; 8'hab: o_b = 8'h62; 8'hac: o_b = 8'h91; 8'had: o_b = 8'h95; 8'hae: o_b = 8'he4; 8'haf: o_b = 8'h79;
            8'hb0: o_b = 8'he7; 8'hb1: o_b = 8'hc8; 8'hb2: o_b = 8'h37; 8'hb3: o_b = 8'h6d; 8'hb4: o_b = 8'h8d; 8'hb5: o_b = 8'hd5; 8'hb6: o_b = 8'h4e; 8'hb7: o_b = 8'ha9; 8'hb8: o_b = 8'h6c; 8'hb9: o_b = 8'h56; 8'hba: o_b = 8'hf4; 8'hbb: o_b = 8'hea; 8'hbc: o_b = 8'h65; 8'hbd: o_b = 8'h7a; 8'hbe: o_b = 8'hae; 8'hbf: o_b = 8'h08;
            8'hc0: o_b = 8'hba; 8'hc1: o_b = 8'h78; 8'hc2: o_b = 8'h25; 8'hc3: o_b = 8'h2e; 8'hc4: o_b = 8'h1c; 8'hc5: o_b = 8'ha6; 8'hc6: o_b = 8'hb4; 8'hc7: o_b = 8'hc6; 8'hc8: o_b = 8'he8; 8'hc9: o_b = 8'hdd; 8'hca: o_b = 8'h74; 8'hcb: o_b = 8'h1f; 8'hcc: o_b = 8'h4b; 8'hcd: o_b = 8'hbd; 8'hce: o_b = 8'h8b; 8'hcf: o_b = 8'h8a;
            8'hd0: o_b = 8'h70; 8'hd1: o_b = 8'h3e; 8'hd2: o_b = 8'hb5; 8'hd3: o_b = 8'h66; 8'hd4: o_b = 8'h48; 8'hd5: o_b = 8'h03; 8'hd6: o_b = 8'hf6; 8'hd7: o_b = 8'h0e; 8'hd8: o_b = 8'h61; 8'hd9: o_b = 8'h35; 8'hda: o_b = 8'h57; 8'hdb: o_b = 8'hb9; 8'hdc: o_b = 8'h86; 8'hdd: o_b = 8'hc1; 8'hde: o_b = 8'h1d; 8'hdf: o_b = 8'h9e;
            8'he0: o_b = 8'he1; 8'he1: o_b = 8'hf8; 8'he2: o_b = 8'h98; 8'he3: o_b = 8'h11; 8'he4: o_b = 8'h69; 8'he5: o_b = 8'hd9; 8'he6: o_b = 8'h8e; 8'he7: o_b = 8'h94; 8'he8: o_b = 8'h9b; 8'he9: o_b = 8'h1e; 8'hea: o_b = 8'h87; 8'heb: o_b = 8'he9; 8'hec: o_b = 8'hce; 8'hed: o_b = 8'h55; 8'hee: o_b = 8'h28; 8'hef: o_b = 8'hdf;
            8'hf0: o_b = 8'h8c; 8'hf1: o_b = 8'ha1; 8'hf2: o_b = 8'h89; 8'hf3: o_b = 8'h0d; 8'hf4: o_b = 8'hbf; 8'hf5: o_b = 8'he6; 8'hf6: o_b = 8'h42; 8'hf7: o_b = 8'h68; 8'hf8: o_b = 8'h41; 8'hf9: o_b = 8'h99; 8'hfa: o_b = 8'h2d; 8'hfb: o_b = 8'h0f; 8'hfc: o_b = 8'hb0; 8'hfd: o_b = 8'h54; 8'hfe: o_b = 8'hbb; 8'hff: o_b = 8'h16;
        endcase
    end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule filling an (NR+1)-entry round-key file, one key per clock.
// Define AES_KEY_CACHE_EN to skip re-expansion when Start repeats the last fully expanded key.
module aes_key_expand
    import aes_key_expand_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [KEY_W-1:0] Key,
    input  logic [3:0]       Round_Idx,
    output logic [KEY_W-1:0] Round_Key,
    output logic             Busy,
    output logic             Done,
    output logic             Keys_Valid
);
    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_busy, r_done, r_kv;
    logic [KEY_W-1:0] r_cur;
    logic [KEY_W-1:0] r_rk [0:NR];
    logic [31:0]      w_rot, w_sub, w_t, w_0, w_1, w_2, w_3;
    logic [KEY_W-1:0] w_next;
    logic             w_cache_hit;
`ifdef AES_KEY_CACHE_EN
    logic [KEY_W-1:0] r_last_key;
    assign w_cache_hit = r_kv && (Key == r_last_key);
`else
    assign w_cache_hit = 1'b0;
`endif
    assign w_rot = {r_cur[23:0], r_cur[31:24]};
    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_key_expand_sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_b(w_sub[8*g +: 8]));
    end
    assign w_t    = w_sub ^ {rcon(r_cnt), 24'h0};
    assign w_0    = r_cur[127:96] ^ w_t;
    assign w_1    = r_cur[95:64] ^ w_0;
    assign w_2    = r_cur[63:32] ^ w_1;
    assign w_3    = r_cur[31:0] ^ w_2;
    assign w_next = {w_0, w_1, w_2, w_3};
    assign Round_Key  = (Round_Idx > 4'(NR)) ? '0 : r_rk[Round_Idx];
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Keys_Valid = r_kv;
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_kv    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (Start) begin
                    r_state <= w_cache_hit ? DONE : EXPAND;
                    r_busy  <= !w_cache_hit;
                    r_done  <= w_cache_hit;
                    r_kv    <= w_cache_hit;
                    r_cnt   <= 4'd1;
                end
                EXPAND: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(NR)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_kv    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // Key file is not reset: contents are only meaningful while Keys_Valid is high.
    always_ff @(posedge CLK) begin
        if (r_state == IDLE && Start && !w_cache_hit) begin
            r_cur    <= Key;
            r_rk[0]  <= Key;
`ifdef AES_KEY_CACHE_EN
            r_last_key <= Key;
`endif
        end else if (r_state == EXPAND) begin
            r_cur        <= w_next;
            r_rk[r_cnt]  <= w_next;
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed + random checks of the key schedule against a GF(2^8)-math reference model.
module tb_aes_key_expand;
    logic         CLK = 1'b0, RST = 1'b1, Start = 1'b0;
    logic [127:0] Key = '0;
    logic [3:0]   Round_Idx = '0;
    logic [127:0] Round_Key;
    logic         Busy, Done, Keys_Valid;
    int           n_assert = 0, n_fail = 0;
    int           lat, dones, nbusy;
    logic         b_hist [0:16], d_hist [0:16], v_hist [0:16];
    logic [127:0] k1, k2;

    aes_key_expand dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Key(Key), .Round_Idx(Round_Idx),
        .Round_Key(Round_Key), .Busy(Busy), .Done(Done), .Keys_Valid(Keys_Valid)
    );

    always #10 CLK = ~CLK;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] p = 8'h01;
        for (int i = 0; i < 254; i++) p = gmul(p, x);
        if (x == 8'h00) p = 8'h00;
        return p ^ rol8(p, 1) ^ rol8(p, 2) ^ rol8(p, 3) ^ rol8(p, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input int idx);
        Round_Idx = 4'(idx);
        #1;
    endtask

    task automatic check_file(input logic [127:0] key, input string tag);
        for (int r = 0; r <= 10; r++) begin
            rd(r);
            chk($sformatf("%s rk%0d", tag, r), Round_Key, model_rk(key, r));
        end
    endtask

    // Start in cycle 0; optional second Start (with new Key) at cycle re_at and RST at cycle rst_at.
    task automatic expand(input logic [127:0] k, input logic [127:0] kb, input int re_at, input int rst_at);
        Start = 1'b1;
        Key   = k;
        lat = 0; dones = 0; nbusy = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge CLK);
            #1;
            b_hist[c] = Busy;
            d_hist[c] = Done;
            v_hist[c] = Keys_Valid;
            if (Busy) nbusy++;
            if (Done) begin
                dones++;
                if (lat == 0) lat = c;
            end
            Start = (c == re_at);
            if (c == re_at) Key = kb;
            RST = (c == rst_at);
        end
        Start = 1'b0;
        RST   = 1'b0;
    endtask

    task automatic chk_full(input string tag);
        chk({tag, " latency"}, 128'(lat), 128'd11);
        chk({tag, " done pulses"}, 128'(dones), 128'd1);
        chk({tag, " busy cycles"}, 128'(nbusy), 128'd10);
        chk({tag, " kv falls"}, 128'(v_hist[1]), 128'd0);
        chk({tag, " kv rises"}, 128'(v_hist[11]), 128'd1);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("reset busy", 128'(Busy), 128'd0);
        chk("reset done", 128'(Done), 128'd0);
        chk("reset kv", 128'(Keys_Valid), 128'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand(k1, k1, 99, 99);
        chk_full("fips");
        chk("fips busy c10", 128'(b_hist[10]), 128'd1);
        chk("fips busy c11", 128'(b_hist[11]), 128'd0);
        chk("fips done c12", 128'(d_hist[12]), 128'd0);
        chk("fips kv hold", 128'(v_hist[16]), 128'd1);
        rd(1);  chk("fips rk1", Round_Key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(10); chk("fips rk10", Round_Key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_file(k1, "fips");

        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        expand(k1, k1, 99, 99);
        chk_full("seq");
        rd(0);  chk("seq rk0", Round_Key, k1);
        rd(10); chk("seq rk10", Round_Key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        for (int n = 0; n < 4; n++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            expand(k1, k1, 99, 99);
            chk_full($sformatf("rand%0d", n));
            check_file(k1, $sformatf("rand%0d", n));
        end

        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = ~k1;
        expand(k1, k2, 4, 99);
        chk_full("restart");
        check_file(k1, "restart");

        expand(k2, k2, 99, 5);
        chk("rst busy", 128'(b_hist[6]), 128'd0);
        chk("rst done", 128'(d_hist[6]), 128'd0);
        chk("rst kv", 128'(v_hist[6]), 128'd0);
        chk("rst no done", 128'(dones), 128'd0);
        k1 = {$urandom, $urandom, $urandom, $urandom};
        expand(k1, k1, 99, 99);
        chk_full("after rst");
        check_file(k1, "after rst");

        for (int r = 11; r <= 15; r++) begin
            rd(r);
            chk($sformatf("idx%0d zero", r), Round_Key, 128'h0);
        end

        Start = 1'b1;
        RST   = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        RST   = 1'b0;
        chk("start+rst busy", 128'(Busy), 128'd0);
        chk("start+rst kv", 128'(Keys_Valid), 128'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("start+rst idle busy", 128'(Busy), 128'd0);
        chk("start+rst idle done", 128'(Done), 128'd0);

        k1 = {$urandom, $urandom, $urandom, $urandom};
        expand(k1, k1, 99, 99);
        chk_full("cache fill");
        expand(k1, k1, 99, 99);
        chk("same key done pulses", 128'(dones), 128'd1);
`ifdef AES_KEY_CACHE_EN
        chk("same key latency", 128'(lat), 128'd1);
        chk("same key kv held", 128'(v_hist[1]), 128'd1);
        chk("same key busy", 128'(nbusy), 128'd0);
`else
        chk("same key latency", 128'(lat), 128'd11);
        chk("same key kv falls", 128'(v_hist[1]), 128'd0);
        chk("same key busy", 128'(nbusy), 128'd10);
`endif
        check_file(k1, "same key");
        k2 = k1 ^ 128'h1;
        expand(k2, k2, 99, 99);
        chk_full("new key");
        check_file(k2, "new key");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
